// File: rtl/xadc_scan_ctrl.sv
// xadc_scan_ctrl
//   Polls two XADC auxiliary channels over the DRP after each end-of-conversion
//   pulse. Reads left then right, accumulates 2^AVG_LOG2 rounds, and publishes
//   the truncated mean of each channel as a zero-extended 12-bit value.
//
// Ports
//   CLK100MHZ    single clock, rising-edge
//   CPU_RESETN   asynchronous active-low reset
//   eoc_i        XADC end-of-conversion pulse (honoured only in IDLE)
//   den_o        DRP enable strobe
//   daddr_o      DRP address (holds last value between requests)
//   dwe_o, di_o  DRP write controls, tied off (read-only use)
//   do_i         DRP read data, conversion result in do_i[15:4]
//   drdy_i       DRP read-data-ready (honoured only in WAIT_L / WAIT_R)
//   dataL/dataR  averaged samples, zero-extended to 16 bits
//   data_valid   one-cycle strobe when dataL/dataR update
//   busy         high whenever the FSM is not in IDLE
//   timeout_err  sticky DRP timeout flag, cleared only by reset
module xadc_scan_ctrl #(
  parameter logic [6:0]  CH_L_ADDR   = 7'h13,
  parameter logic [6:0]  CH_R_ADDR   = 7'h12,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        eoc_i,
  output logic        den_o,
  output logic [6:0]  daddr_o,
  output logic        dwe_o,
  output logic [15:0] di_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  output logic [15:0] dataL,
  output logic [15:0] dataR,
  output logic        data_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned   AW    = 12 + AVG_LOG2;
  localparam int unsigned   RW    = AVG_LOG2 + 1;
  localparam logic [RW-1:0] RFULL = RW'(1 << AVG_LOG2);
  localparam logic [7:0]    TMO   = 8'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE,
    REQ_L,
    WAIT_L,
    REQ_R,
    WAIT_R,
    UPDATE
  } state_t;

  state_t        state, nstate;
  logic          rst_meta, rst_sync;
  logic [AW-1:0] acc_l, acc_r;
  logic [RW-1:0] rnd;
  logic [7:0]    wcnt;
  logic [11:0]   sample;
  logic [11:0]   avg_l, avg_r;
  logic          wait_st;
  logic          tmo_hit;
  logic          unused_lsbs;

  assign sample      = do_i[15:4];
  assign unused_lsbs = ^do_i[3:0];
  assign avg_l       = 12'(acc_l >> AVG_LOG2);
  assign avg_r       = 12'(acc_r >> AVG_LOG2);

  assign dwe_o = 1'b0;
  assign di_o  = '0;
  assign busy  = (state != IDLE);

  assign wait_st = (state == WAIT_L) || (state == WAIT_R);
  // A drdy_i arriving on the limit cycle still wins over the timeout.
  assign tmo_hit = wait_st && !drdy_i && (wcnt == TMO);

  // Reset release is re-timed through two flops; eoc_i is only honoured once
  // the synchroniser output is high, so the FSM cannot start a round on the
  // first edges after deassertion.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    den_o  = 1'b0;
    case (state)
      IDLE: begin
        if (eoc_i && rst_sync) begin
          nstate = REQ_L;
        end
      end
      REQ_L: begin
        den_o  = 1'b1;
        nstate = WAIT_L;
      end
      WAIT_L: begin
        if (drdy_i) begin
          nstate = REQ_R;
        end else if (tmo_hit) begin
          nstate = IDLE;
        end
      end
      REQ_R: begin
        den_o  = 1'b1;
        nstate = WAIT_R;
      end
      WAIT_R: begin
        if (drdy_i) begin
          nstate = UPDATE;
        end else if (tmo_hit) begin
          nstate = IDLE;
        end
      end
      UPDATE: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      daddr_o     <= CH_L_ADDR;
      wcnt        <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      rnd         <= '0;
      dataL       <= '0;
      dataR       <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      // Address is loaded as the request state is entered so it is already
      // stable while den_o is high, and simply holds afterwards.
      if (nstate == REQ_L) begin
        daddr_o <= CH_L_ADDR;
      end else if (nstate == REQ_R) begin
        daddr_o <= CH_R_ADDR;
      end

      if ((state == REQ_L) || (state == REQ_R)) begin
        wcnt <= '0;
      end else if (wait_st && !drdy_i && !tmo_hit) begin
        wcnt <= wcnt + 8'd1;
      end

      case (state)
        WAIT_L: begin
          if (drdy_i) begin
            acc_l <= acc_l + AW'(sample);
          end
        end
        WAIT_R: begin
          if (drdy_i) begin
            acc_r <= acc_r + AW'(sample);
            rnd   <= rnd + RW'(1);
          end
        end
        UPDATE: begin
          if (rnd == RFULL) begin
            dataL      <= {4'h0, avg_l};
            dataR      <= {4'h0, avg_r};
            data_valid <= 1'b1;
            acc_l      <= '0;
            acc_r      <= '0;
            rnd        <= '0;
          end
        end
        default: begin
        end
      endcase

      // The partial round is thrown away so the next average is not skewed.
      if (tmo_hit) begin
        timeout_err <= 1'b1;
        acc_l       <= '0;
        acc_r       <= '0;
        rnd         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_xadc_scan_ctrl.sv
module tb_xadc_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        eoc = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] do_d = 16'h0000;
  logic        den_o;
  logic [6:0]  daddr_o;
  logic        dwe_o;
  logic [15:0] di_o;
  logic [15:0] dataL;
  logic [15:0] dataR;
  logic        data_valid;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  xadc_scan_ctrl #(
    .CH_L_ADDR  (7'h13),
    .CH_R_ADDR  (7'h12),
    .AVG_LOG2   (2),
    .TIMEOUT_CYC(255)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .eoc_i      (eoc),
    .den_o      (den_o),
    .daddr_o    (daddr_o),
    .dwe_o      (dwe_o),
    .di_o       (di_o),
    .do_i       (do_d),
    .drdy_i     (drdy),
    .dataL      (dataL),
    .dataR      (dataR),
    .data_valid (data_valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // One round: eoc pulse, drdy one cycle after each den_o. Observations are
  // taken on negedges: step 1 REQ_L, 2 WAIT_L, 3 REQ_R, 4 WAIT_R, 5 UPDATE,
  // 6 IDLE (valid strobe if round completes), 7 IDLE.
  task automatic run_round(input logic [15:0] l, input logic [15:0] r, input bit eocw,
                           output int dens, output int vpos, output int serr);
    dens = 0;
    vpos = -1;
    serr = 0;
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      if (den_o) dens++;
      if (data_valid) begin
        if (vpos < 0) vpos = s;
        else serr++;
      end
      case (s)
        1:       if (!(den_o && daddr_o == 7'h13 && busy)) serr++;
        3:       if (!(den_o && daddr_o == 7'h12 && busy)) serr++;
        2, 4, 5: if (den_o || !busy) serr++;
        default: if (busy) serr++;
      endcase
      drdy = (s == 2 || s == 4);
      do_d = (s == 2) ? l : ((s == 4) ? r : 16'hA5A5);
      eoc  = eocw && (s == 2);
      @(negedge clk);
    end
    drdy = 1'b0;
    eoc  = 1'b0;
  endtask

  task automatic run_set(input logic [3:0][15:0] l, input logic [3:0][15:0] r, input bit eocw,
                         output int dens, output int serr, output int early_v, output int vpos4);
    int d, v, e;
    dens = 0;
    serr = 0;
    early_v = 0;
    vpos4 = -1;
    for (int i = 0; i < 4; i++) begin
      run_round(l[i], r[i], eocw, d, v, e);
      dens += d;
      serr += e;
      if (i < 3) begin
        if (v >= 0) early_v++;
      end else begin
        vpos4 = v;
      end
    end
  endtask

  // Drive a round up to the first WAIT_R negedge (wait counter freshly cleared).
  task automatic start_to_wait_r(input logic [15:0] l);
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    @(negedge clk);
    drdy = 1'b1;
    do_d = l;
    @(negedge clk);
    drdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (den_o !== 1'b0) begin failures++; $display("FAIL reset_den got=%0b exp=0", den_o); end
    checks++; if (daddr_o !== 7'h13) begin failures++; $display("FAIL reset_daddr got=%0h exp=13", daddr_o); end
    checks++; if (dwe_o !== 1'b0) begin failures++; $display("FAIL reset_dwe got=%0b exp=0", dwe_o); end
    checks++; if (di_o !== 16'h0) begin failures++; $display("FAIL reset_di got=%0h exp=0", di_o); end
    checks++; if (dataL !== 16'h0) begin failures++; $display("FAIL reset_dataL got=%0d exp=0", dataL); end
    checks++; if (dataR !== 16'h0) begin failures++; $display("FAIL reset_dataR got=%0d exp=0", dataR); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", data_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_terr got=%0b exp=0", timeout_err); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    eoc = 1'b1;
    @(posedge clk);
    #1;
    eoc = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_sync_first_edge busy got=%0b exp=0", busy); end
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_settle busy got=%0b exp=0", busy); end
  endtask

  task automatic test_average();
    int dens, serr, ev, v4;
    run_set({4{16'h7D00}}, {4{16'h3E80}}, 1'b0, dens, serr, ev, v4);
    checks++; if (dens != 8) begin failures++; $display("FAIL avg_den_count got=%0d exp=8", dens); end
    checks++; if (serr != 0) begin failures++; $display("FAIL avg_sequence errors got=%0d exp=0", serr); end
    checks++; if (ev != 0) begin failures++; $display("FAIL avg_early_valid got=%0d exp=0", ev); end
    checks++; if (v4 != 6) begin failures++; $display("FAIL avg_valid_latency got=%0d exp=6", v4); end
    checks++; if (dataL !== 16'd2000) begin failures++; $display("FAIL avg_dataL got=%0d exp=2000", dataL); end
    checks++; if (dataR !== 16'd1000) begin failures++; $display("FAIL avg_dataR got=%0d exp=1000", dataR); end
  endtask

  task automatic test_mean();
    int dens, serr, ev, v4;
    // L = 100,200,300,400 -> 250 ; R = 1,2,3,5 -> 11/4 truncates to 2
    run_set({16'h1900, 16'h12C0, 16'h0C80, 16'h0640}, {16'h0050, 16'h0030, 16'h0020, 16'h0010},
            1'b0, dens, serr, ev, v4);
    checks++; if (serr != 0 || ev != 0 || v4 != 6) begin failures++; $display("FAIL mean_sequence got serr=%0d early=%0d vpos=%0d exp 0/0/6", serr, ev, v4); end
    checks++; if (dataL !== 16'd250) begin failures++; $display("FAIL mean_dataL got=%0d exp=250", dataL); end
    checks++; if (dataR !== 16'd2) begin failures++; $display("FAIL mean_dataR_trunc got=%0d exp=2", dataR); end
  endtask

  task automatic test_max();
    int dens, serr, ev, v4;
    // low nibble set on purpose: it must not reach the accumulator
    run_set({4{16'hFFFF}}, {4{16'h000F}}, 1'b0, dens, serr, ev, v4);
    checks++; if (serr != 0 || ev != 0 || v4 != 6) begin failures++; $display("FAIL max_sequence got serr=%0d early=%0d vpos=%0d exp 0/0/6", serr, ev, v4); end
    checks++; if (dataL !== 16'd4095) begin failures++; $display("FAIL max_dataL got=%0d exp=4095", dataL); end
    checks++; if (dataR !== 16'd0) begin failures++; $display("FAIL max_dataR got=%0d exp=0", dataR); end
  endtask

  task automatic test_eoc_drop();
    int dens, serr, ev, v4;
    run_set({4{16'h7D00}}, {4{16'h3E80}}, 1'b1, dens, serr, ev, v4);
    checks++; if (dens != 8) begin failures++; $display("FAIL eocdrop_den_count got=%0d exp=8", dens); end
    checks++; if (serr != 0 || ev != 0 || v4 != 6) begin failures++; $display("FAIL eocdrop_sequence got serr=%0d early=%0d vpos=%0d exp 0/0/6", serr, ev, v4); end
    checks++; if (dataL !== 16'd2000 || dataR !== 16'd1000) begin failures++; $display("FAIL eocdrop_data got=%0d/%0d exp=2000/1000", dataL, dataR); end
  endtask

  task automatic test_accept_limit();
    int bad, d, v, e, ev;
    bad = 0;
    ev = 0;
    start_to_wait_r(16'h0640);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (!busy || timeout_err) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL limit_wait_hold bad_cycles got=%0d exp=0", bad); end
    drdy = 1'b1;
    do_d = 16'h0320;
    @(negedge clk);
    drdy = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL limit_accept terr got=%0b exp=0", timeout_err); end
    checks++; if (busy !== 1'b1 || den_o !== 1'b0) begin failures++; $display("FAIL limit_update busy/den got=%0b/%0b exp=1/0", busy, den_o); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || data_valid !== 1'b0) begin failures++; $display("FAIL limit_idle busy/valid got=%0b/%0b exp=0/0", busy, data_valid); end
    run_round(16'h0C80, 16'h0320, 1'b0, d, v, e);
    if (v >= 0) ev++;
    run_round(16'h12C0, 16'h0320, 1'b0, d, v, e);
    if (v >= 0) ev++;
    run_round(16'h1900, 16'h0320, 1'b0, d, v, e);
    checks++; if (ev != 0 || v != 6 || e != 0) begin failures++; $display("FAIL limit_set got early=%0d vpos=%0d serr=%0d exp 0/6/0", ev, v, e); end
    checks++; if (dataL !== 16'd250 || dataR !== 16'd50) begin failures++; $display("FAIL limit_data got=%0d/%0d exp=250/50", dataL, dataR); end
  endtask

  task automatic test_timeout();
    int bad, dens, serr, ev, v4;
    bad = 0;
    start_to_wait_r(16'hFFF0);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (!busy || timeout_err) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL tmo_wait_hold bad_cycles got=%0d exp=0", bad); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%0b exp=1", timeout_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_idle busy got=%0b exp=0", busy); end
    @(negedge clk);
    checks++; if (data_valid !== 1'b0 || dataL !== 16'd250) begin failures++; $display("FAIL tmo_outputs_hold valid/dataL got=%0b/%0d exp=0/250", data_valid, dataL); end
    run_set({4{16'h7D00}}, {4{16'h3E80}}, 1'b0, dens, serr, ev, v4);
    checks++; if (serr != 0 || ev != 0 || v4 != 6) begin failures++; $display("FAIL tmo_recover_seq got serr=%0d early=%0d vpos=%0d exp 0/0/6", serr, ev, v4); end
    checks++; if (dataL !== 16'd2000 || dataR !== 16'd1000) begin failures++; $display("FAIL tmo_recover_data got=%0d/%0d exp=2000/1000", dataL, dataR); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%0b exp=1", timeout_err); end
  endtask

  task automatic test_stray_drdy();
    int bad, dens, serr, ev, v4;
    bad = 0;
    drdy = 1'b1;
    do_d = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      if (busy || data_valid || den_o) bad++;
    end
    drdy = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL stray_idle bad_cycles got=%0d exp=0", bad); end
    run_set({4{16'h1900}}, {4{16'h3200}}, 1'b0, dens, serr, ev, v4);
    checks++; if (serr != 0 || ev != 0 || v4 != 6) begin failures++; $display("FAIL stray_seq got serr=%0d early=%0d vpos=%0d exp 0/0/6", serr, ev, v4); end
    checks++; if (dataL !== 16'd400 || dataR !== 16'd800) begin failures++; $display("FAIL stray_data got=%0d/%0d exp=400/800", dataL, dataR); end
  endtask

  task automatic test_reset_mid();
    int bad, dens, serr, ev, v4;
    bad = 0;
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dataL !== 16'h0 || dataR !== 16'h0 || data_valid !== 1'b0) begin failures++; $display("FAIL rstmid_data got=%0d/%0d/%0b exp=0/0/0", dataL, dataR, data_valid); end
    checks++; if (busy !== 1'b0 || den_o !== 1'b0 || daddr_o !== 7'h13) begin failures++; $display("FAIL rstmid_ctrl busy/den/daddr got=%0b/%0b/%0h exp=0/0/13", busy, den_o, daddr_o); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rstmid_terr got=%0b exp=0", timeout_err); end
    @(negedge clk);
    #2 rst_n = 1'b1;
    drdy = 1'b1;
    do_d = 16'hFFFF;
    repeat (2) begin
      @(negedge clk);
      if (busy || data_valid) bad++;
    end
    drdy = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_late_drdy bad_cycles got=%0d exp=0", bad); end
    run_set({4{16'h7D00}}, {4{16'h3E80}}, 1'b0, dens, serr, ev, v4);
    checks++; if (serr != 0 || ev != 0 || v4 != 6) begin failures++; $display("FAIL rstmid_seq got serr=%0d early=%0d vpos=%0d exp 0/0/6", serr, ev, v4); end
    checks++; if (dataL !== 16'd2000 || dataR !== 16'd1000) begin failures++; $display("FAIL rstmid_data_after got=%0d/%0d exp=2000/1000", dataL, dataR); end
  endtask

  initial begin
    test_reset();
    test_average();
    test_mean();
    test_max();
    test_eoc_drop();
    test_accept_limit();
    test_timeout();
    test_stray_drdy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xadc_scan_ctrl.md
XADC_SCAN_CTRL -- requirements
Module: xadc_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CH_L_ADDR, 7'h13, DRP address of left channel (vauxp3)
- CH_R_ADDR, 7'h12, DRP address of right channel (vauxp2)
- AVG_LOG2, 2, log2 of samples averaged per output (range 0..4)
- TIMEOUT_CYC, 255, max cycles waiting for drdy_i (range 1..255)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK100MHZ  in  1  single clock; all state changes on its rising edge
- CPU_RESETN  in  1  reset, asynchronous, active-low
- eoc_i  in  1  XADC end-of-conversion pulse
- den_o  out  1  DRP enable strobe
- daddr_o  out  7  DRP address
- dwe_o  out  1  DRP write enable, constant 0
- di_o  out  16  DRP write data, constant 0
- do_i  in  16  DRP read data; result in do_i[15:4]
- drdy_i  in  1  DRP read-data-ready
- dataL  out  16  averaged left sample, zero-extended 12-bit
- dataR  out  16  averaged right sample, zero-extended 12-bit
- data_valid  out  1  one-cycle strobe on dataL/dataR update
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky DRP timeout flag

Function
REQ-003 FSM states SHALL be IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, UPDATE.
REQ-004 IDLE SHALL go to REQ_L on the edge sampling eoc_i=1, and otherwise stay in IDLE.
REQ-005 eoc_i SHALL be ignored outside IDLE; the pulse is dropped, not queued.
REQ-006 REQ_L/REQ_R SHALL last exactly one cycle, with den_o=1 and daddr_o=CH_L_ADDR/CH_R_ADDR, then go to WAIT_L/WAIT_R.
REQ-007 den_o SHALL be 0 in all other states, and daddr_o SHALL hold its last value.
REQ-008 drdy_i SHALL be sampled only in WAIT_L/WAIT_R; drdy_i in any other state is ignored.
REQ-009 WAIT_L SHALL, on drdy_i=1, add do_i[15:4] into the left accumulator and go to REQ_R.
REQ-010 WAIT_R SHALL, on drdy_i=1, add do_i[15:4] into the right accumulator, increment the round counter, and go to UPDATE.
REQ-011 Each accumulator SHALL be 12+AVG_LOG2 bits wide and SHALL NOT overflow within 2^AVG_LOG2 samples.
REQ-012 The round counter SHALL be AVG_LOG2+1 bits wide.
REQ-013 The wait counter SHALL clear on entry to each WAIT state and increment every WAIT cycle without drdy_i.
REQ-014 On reaching TIMEOUT_CYC without drdy_i, the block SHALL set timeout_err=1, clear both accumulators and the round counter, and go to IDLE; the partial round is discarded.
REQ-015 drdy_i=1 on the same cycle the wait counter reaches TIMEOUT_CYC SHALL count as success, not timeout.
REQ-016 UPDATE SHALL last one cycle and then go to IDLE.
REQ-017 In UPDATE, if round counter equals 2^AVG_LOG2, dataL/dataR SHALL load accumulator>>AVG_LOG2 zero-extended to 16 bits, data_valid SHALL be 1 in the following cycle only, and accumulators and round counter SHALL clear.
REQ-018 In UPDATE with fewer rounds complete, outputs SHALL hold and data_valid SHALL stay 0.
REQ-019 Latency: eoc_i at edge k gives den_o=1 in cycle k+1; with drdy_i one cycle after each den_o, data_valid asserts 6 cycles after eoc_i for the completing round.
REQ-020 timeout_err SHALL clear only on reset.

Reset
REQ-021 CPU_RESETN=0 SHALL immediately force IDLE, with den_o=0, daddr_o=CH_L_ADDR, dwe_o=0, di_o=0, dataL=0, dataR=0, data_valid=0, busy=0, timeout_err=0, accumulators=0 and counters=0.
REQ-022 Reset asserted mid-round SHALL abandon the DRP transaction; a late drdy_i after release SHALL be ignored per REQ-008.
REQ-023 Reset release SHALL be synchronised so the FSM leaves IDLE no earlier than the second rising edge after deassertion.

Verification
REQ-024 With AVG_LOG2=2, four eoc_i rounds at do_i=16'h7D00 (L) and 16'h3E80 (R) SHALL give dataL=2000 and dataR=1000 with one data_valid pulse after round 4 and none after rounds 1-3.
REQ-025 Samples L=100,200,300,400 SHALL give dataL=250 (truncated mean); L=4095 x4 SHALL give dataL=4095 with no overflow.
REQ-026 A second eoc_i pulse during WAIT_L SHALL be dropped, with exactly one den_o per channel per round.
REQ-027 With drdy_i withheld for 255 cycles in WAIT_R, timeout_err SHALL rise, the FSM SHALL be in IDLE next cycle, and the next 4 good rounds SHALL give one valid output unaffected by the aborted round.
REQ-028 drdy_i exactly at cycle 255 SHALL be accepted with timeout_err=0; a stray drdy_i in IDLE SHALL change nothing.
REQ-029 CPU_RESETN pulsed low in WAIT_L SHALL zero all outputs asynchronously; after release, a full 4-round sequence SHALL give correct averages.
